mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory bus arbiter and wait-state sequencer between the b16 CPU bus and the debug-UART bus (`dbg_uart`). It grants one requester at a time onto the shared memory bus and decodes the address to one of three targets: SFR block, 8 KB boot RAM, or external async SRAM. It generates the SRAM strobes with a programmable wait-state count and returns read data plus a one-cycle ready pulse to the granted requester. It replaces the combinational `csu` mux and `READY` counter in the top level.

## Interface
Parameters:
- `SRAM_WS`, 3: SRAM wait-state count; legal range 1..15.
- `BOOT_WS`, 1: boot RAM wait-state count; legal range 0..15. Boot RAM has synchronous read, so it needs at least 1.
- `SFR_WS`, 0: SFR wait-state count; legal range 0..15.

Ports:
- `clk`  in  1  system clock, rising edge
- `nreset`  in  1  asynchronous reset, active low
- `c_addr`, `c_wdata`  in  16 each  CPU byte address and write data
- `c_r`  in  1  CPU read request
- `c_w`  in  2  CPU write byte enables: [1] high byte, [0] low byte
- `c_rdata`  out  16  CPU read data
- `c_rdy`  out  1  CPU transfer-done pulse
- `u_addr`, `u_wdata`, `u_r`, `u_w`, `u_rdata`, `u_rdy`: same as the `c_*` ports, for the debug port
- `m_addr`  out  16  latched address of the granted request
- `m_wdata`  out  16  latched write data
- `m_r`  out  1  latched read flag
- `m_w`  out  2  latched write byte enables
- `boot_we`  out  2  boot RAM byte write strobes
- `boot_rdata`  in  16  boot RAM read data
- `sfr_cs`  out  1  SFR access strobe
- `sfr_rdata`  in  16  SFR read data
- `sram_addr`  out  15  SRAM word address, equal to `m_addr[15:1]`
- `sram_dq_in`  in  16  SRAM data pins, input side
- `sram_dq_oe`  out  1  drive `m_wdata` onto the SRAM data pins
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  SRAM control, active low
- `gnt`  out  2  current grant: [1] debug, [0] CPU
- `busy`  out  1  state is not IDLE

## Operation
- A port is requesting when `r | |w` is high.
- If `r` and `w` are both set, the access is a read and `w` is ignored.
- Requesters hold address, data and strobes stable from the start of a request until they sample their `rdy` high.
- **Arbitration** (in IDLE only):
  - A single requester is granted immediately.
  - If both request, the port not granted last wins (round-robin). The `last` register resets to CPU, so the debug port wins the first tie.
  - No preemption: a grant stays until that transfer completes.
- **Address decode** on the latched address:
  - `addr[15:8]==8'hFF` → SFR
  - `addr[15:13]==3'b001` → boot RAM
  - anything else → SRAM
- **State machine**:
  - IDLE: on any request, latch grant, `m_*` and target; load `cnt` with the target's WS; go to ACCESS.
  - ACCESS: if `cnt!=0`, decrement and stay. If `cnt==0`, capture the target's read data into the holding register of the granted port and go to DONE.
  - DONE: assert the granted port's `rdy` for one cycle, update `last`, clear `gnt`, go to IDLE.
- **SRAM signals**, driven in ACCESS only, when the target is SRAM:
  - `ce_n` low for all of ACCESS.
  - Read: `oe_n` low; `ub_n` and `lb_n` low.
  - Write: `sram_dq_oe` high for all of ACCESS; `we_n` low while `cnt!=0` and high in the final ACCESS cycle (data hold); `ub_n=~m_w[1]`, `lb_n=~m_w[0]`.
- **Boot RAM**: `boot_we = m_w` for the single ACCESS cycle with `cnt==0`, only on writes to boot RAM.
- **SFR**: `sfr_cs` high for the single ACCESS cycle with `cnt==0`.
- **Read data**: `c_rdata` and `u_rdata` hold their last captured value until the next read for that port. Writes do not change them.
- **Reset**, asynchronous:
  - State → IDLE; `gnt`, `last`, `cnt`, `m_*`, `boot_we`, `sfr_cs`, `sram_dq_oe`, `busy`, `c_rdy`, `u_rdy` → 0; `c_rdata`, `u_rdata` → 0.
  - All `sram_*_n` → 1.
  - Reset in the middle of an access aborts it with no `rdy`. A write already in progress may be partially committed.

## Timing
- Request sampled at rising edge 0 → ACCESS during cycles 1..1+WS → DONE (rdy high) during cycle 2+WS.
- Latency from request to `rdy` is 2+WS cycles. Back-to-back requests from one port complete every 3+WS cycles.
- The requester changes or drops its request on the edge where it sees `rdy`. IDLE samples the new request one cycle later.
- A request dropped before grant is simply not granted.
- All outputs are registered or decoded from registered state only. There is no combinational path from request inputs to strobes.

## Test plan
- CPU reads SRAM at 0x1234 with `sram_dq_in=0xBEEF`, SRAM_WS=3 → `sram_addr=0x091A`; `oe_n` and `ce_n` low for 4 cycles; `c_rdy` 5 cycles after the request; `c_rdata=0xBEEF`.
- Debug writes high byte only (`u_w=2'b10`) of 0xA5xx to SRAM 0x0100 → `we_n` low for 3 cycles then high for 1; `ub_n=0`, `lb_n=1`; `sram_dq_oe` high for 4 cycles.
- Both ports request continuously, first tie → grants go debug, CPU, debug, CPU; each `rdy` pulse is exactly 1 cycle.
- CPU writes 0x55AA to boot RAM 0x2002 (BOOT_WS=1) → `boot_we=2'b11` for one cycle with `m_addr=0x2002`. A following read of the same address returns `boot_rdata` and `c_rdy` at cycle 3.
- CPU accesses SFR 0xFF10 (SFR_WS=0) → `sfr_cs` for one cycle; `c_rdy` 2 cycles after the request; no SRAM strobe is asserted.
- `nreset` pulsed low during cycle 2 of an SRAM write → all strobes go inactive immediately; no `rdy`; state IDLE; the next request behaves normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the CPU and debug-UART buses, with address decode and a wait-state sequencer.
// Latency is 2+WS cycles from request to rdy. A requester holds its request until it sees a one-cycle rdy pulse.
module mem_arbiter #(
  parameter int SRAM_WS = 3,
  parameter int BOOT_WS = 1,
  parameter int SFR_WS  = 0
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  input  logic        c_r,
  input  logic [1:0]  c_w,
  output logic [15:0] c_rdata,
  output logic        c_rdy,
  input  logic [15:0] u_addr,
  input  logic [15:0] u_wdata,
  input  logic        u_r,
  input  logic [1:0]  u_w,
  output logic [15:0] u_rdata,
  output logic        u_rdy,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_r,
  output logic [1:0]  m_w,
  output logic [1:0]  boot_we,
  input  logic [15:0] boot_rdata,
  output logic        sfr_cs,
  input  logic [15:0] sfr_rdata,
  output logic [14:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [1:0]  gnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {T_SFR, T_BOOT, T_SRAM} tgt_t;

  function automatic tgt_t decode(input logic [15:0] a);
    if (a[15:8] == 8'hFF)       return T_SFR;
    else if (a[15:13] == 3'b001) return T_BOOT;
    else                         return T_SRAM;
  endfunction

  function automatic logic [3:0] ws_of(input tgt_t t);
    case (t)
      T_SFR:   return 4'(SFR_WS);
      T_BOOT:  return 4'(BOOT_WS);
      default: return 4'(SRAM_WS);
    endcase
  endfunction

  state_t      state, state_nxt;
  logic        last;
  logic [3:0]  cnt;

  logic        c_req, u_req, any_req, pick_u;
  logic [15:0] sel_addr, sel_wdata;
  logic        sel_r;
  logic [1:0]  sel_w;
  tgt_t        m_tgt;
  logic [15:0] rd_mux;
  logic        acc, cnt_zero, is_sram, is_boot, is_sfr;

  assign c_req   = c_r | (|c_w);
  assign u_req   = u_r | (|u_w);
  assign any_req = c_req | u_req;
  // last==1 means debug was served last, so a tie goes to the CPU
  assign pick_u  = u_req & (~c_req | ~last);

  assign sel_addr  = pick_u ? u_addr  : c_addr;
  assign sel_wdata = pick_u ? u_wdata : c_wdata;
  assign sel_r     = pick_u ? u_r     : c_r;
  assign sel_w     = pick_u ? u_w     : c_w;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_tgt = decode(m_addr);
  always_comb begin
    rd_mux = sram_dq_in;
    case (m_tgt)
      T_SFR:   rd_mux = sfr_rdata;
      T_BOOT:  rd_mux = boot_rdata;
      default: rd_mux = sram_dq_in;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      gnt     <= 2'b00;
      last    <= 1'b0;
      cnt     <= 4'd0;
      m_addr  <= 16'h0;
      m_wdata <= 16'h0;
      m_r     <= 1'b0;
      m_w     <= 2'b00;
      c_rdata <= 16'h0;
      u_rdata <= 16'h0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt     <= pick_u ? 2'b10 : 2'b01;
          m_addr  <= sel_addr;
          m_wdata <= sel_wdata;
          m_r     <= sel_r;
          m_w     <= sel_r ? 2'b00 : sel_w;
          cnt     <= ws_of(decode(sel_addr));
        end
        ACCESS: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (m_r) begin
            if (gnt[0]) c_rdata <= rd_mux;
            else        u_rdata <= rd_mux;
          end
        end
        DONE: begin
          last <= gnt[1];
          gnt  <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from registered state only; idle/reset values fall out of state==IDLE
  assign acc      = (state == ACCESS);
  assign cnt_zero = (cnt == 4'd0);
  assign is_sram  = acc & (m_tgt == T_SRAM);
  assign is_boot  = acc & (m_tgt == T_BOOT);
  assign is_sfr   = acc & (m_tgt == T_SFR);

  assign c_rdy      = (state == DONE) & gnt[0];
  assign u_rdy      = (state == DONE) & gnt[1];
  assign busy       = (state != IDLE);
  assign sram_addr  = m_addr[15:1];
  assign sram_ce_n  = ~is_sram;
  assign sram_oe_n  = ~(is_sram & m_r);
  assign sram_dq_oe = is_sram & ~m_r;
  // we_n rises in the last access cycle so data is held past the write edge
  assign sram_we_n  = ~(is_sram & ~m_r & ~cnt_zero);
  assign sram_ub_n  = ~(is_sram & (m_r | m_w[1]));
  assign sram_lb_n  = ~(is_sram & (m_r | m_w[0]));
  assign boot_we    = (is_boot & cnt_zero & ~m_r) ? m_w : 2'b00;
  assign sfr_cs     = is_sfr & cnt_zero;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with default wait states (SRAM 3, boot 1, SFR 0).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] c_addr, c_wdata, c_rdata, u_addr, u_wdata, u_rdata;
  logic        c_r, u_r, c_rdy, u_rdy;
  logic [1:0]  c_w, u_w;
  logic [15:0] m_addr, m_wdata, boot_rdata, sfr_rdata, sram_dq_in;
  logic        m_r, sfr_cs, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, busy;
  logic [1:0]  m_w, boot_we, gnt;
  logic [14:0] sram_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .nreset(nreset),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_r(c_r), .c_w(c_w), .c_rdata(c_rdata), .c_rdy(c_rdy),
    .u_addr(u_addr), .u_wdata(u_wdata), .u_r(u_r), .u_w(u_w), .u_rdata(u_rdata), .u_rdy(u_rdy),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_r(m_r), .m_w(m_w),
    .boot_we(boot_we), .boot_rdata(boot_rdata), .sfr_cs(sfr_cs), .sfr_rdata(sfr_rdata),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .gnt(gnt), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    nreset = 1'b0;
    c_addr = '0; c_wdata = '0; c_r = 0; c_w = '0;
    u_addr = '0; u_wdata = '0; u_r = 0; u_w = '0;
    boot_rdata = '0; sfr_rdata = '0; sram_dq_in = '0;
    cyc(); cyc();
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_rdy", {c_rdy, u_rdy}, 2'b00);
    check("rst_m_addr", m_addr, 0);
    nreset = 1'b1;
    cyc();

    // Round-robin: both read SFR continuously; first tie goes to debug
    c_addr = 16'hFF10; u_addr = 16'hFF20; sfr_rdata = 16'h1357;
    c_r = 1; u_r = 1;
    for (int i = 1; i <= 11; i++) begin
      cyc();
      check($sformatf("rr_u_rdy_%0d", i), u_rdy, (i == 2 || i == 8));
      check($sformatf("rr_c_rdy_%0d", i), c_rdy, (i == 5 || i == 11));
      if (i == 1) check("rr_first_gnt", gnt, 2'b10);
      if (i == 4) check("rr_second_gnt", gnt, 2'b01);
    end
    c_r = 0; u_r = 0;
    cyc();
    check("rr_idle", busy, 0);
    check("rr_u_rdata", u_rdata, 16'h1357);
    check("rr_c_rdata", c_rdata, 16'h1357);

    // CPU SRAM read at 0x1234
    c_addr = 16'h1234; c_r = 1; sram_dq_in = 16'hBEEF;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("rd_ce_n_%0d", i), sram_ce_n, 0);
      check($sformatf("rd_oe_n_%0d", i), sram_oe_n, 0);
      check($sformatf("rd_rdy_%0d", i), c_rdy, 0);
    end
    check("rd_sram_addr", sram_addr, 15'h091A);
    check("rd_we_n", sram_we_n, 1);
    check("rd_ublb", {sram_ub_n, sram_lb_n}, 2'b00);
    cyc();
    check("rd_c_rdy", c_rdy, 1);
    check("rd_c_rdata", c_rdata, 16'hBEEF);
    check("rd_ce_n_done", sram_ce_n, 1);
    c_r = 0;
    cyc();
    check("rd_rdy_pulse", c_rdy, 0);

    // Debug high-byte SRAM write to 0x0100
    u_addr = 16'h0100; u_wdata = 16'hA55A; u_w = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("wr_we_n_%0d", i), sram_we_n, (i == 4));
      check($sformatf("wr_dq_oe_%0d", i), sram_dq_oe, 1);
      check($sformatf("wr_ublb_%0d", i), {sram_ub_n, sram_lb_n}, 2'b01);
    end
    check("wr_oe_n", sram_oe_n, 1);
    check("wr_m_wdata", m_wdata, 16'hA55A);
    cyc();
    check("wr_u_rdy", u_rdy, 1);
    check("wr_dq_oe_done", sram_dq_oe, 0);
    check("wr_u_rdata_kept", u_rdata, 16'h1357);
    u_w = 2'b00;
    cyc();

    // CPU boot RAM write then read at 0x2002
    c_addr = 16'h2002; c_wdata = 16'h55AA; c_w = 2'b11;
    cyc();
    check("bw_we_1", boot_we, 2'b00);
    cyc();
    check("bw_we_2", boot_we, 2'b11);
    check("bw_m_addr", m_addr, 16'h2002);
    check("bw_ce_n", sram_ce_n, 1);
    cyc();
    check("bw_rdy", c_rdy, 1);
    check("bw_we_done", boot_we, 2'b00);
    check("bw_rdata_kept", c_rdata, 16'hBEEF);
    c_w = 2'b00;
    cyc();
    c_r = 1; boot_rdata = 16'h6789;
    cyc();
    check("br_rdy_1", c_rdy, 0);
    cyc();
    check("br_rdy_2", c_rdy, 0);
    check("br_we", boot_we, 2'b00);
    cyc();
    check("br_rdy_3", c_rdy, 1);
    check("br_rdata", c_rdata, 16'h6789);
    c_r = 0;
    cyc();

    // CPU SFR read at 0xFF10
    c_addr = 16'hFF10; c_r = 1; sfr_rdata = 16'hC3C3;
    cyc();
    check("sfr_cs_1", sfr_cs, 1);
    check("sfr_no_sram", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("sfr_rdy_1", c_rdy, 0);
    cyc();
    check("sfr_rdy_2", c_rdy, 1);
    check("sfr_cs_2", sfr_cs, 0);
    check("sfr_rdata", c_rdata, 16'hC3C3);
    c_r = 0;
    cyc();

    // Reset during cycle 2 of an SRAM write
    c_addr = 16'h0200; c_wdata = 16'h1111; c_w = 2'b11;
    cyc();
    check("ab_we_n_1", sram_we_n, 0);
    cyc();
    nreset = 1'b0; c_w = 2'b00;
    #1;
    check("ab_strobes", {sram_ce_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}, 5'b11110);
    check("ab_busy", busy, 0);
    check("ab_gnt", gnt, 2'b00);
    check("ab_c_rdata", c_rdata, 0);
    #2 nreset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check($sformatf("ab_no_rdy_%0d", i), c_rdy, 0);
    end

    // Normal SRAM read after abort
    c_addr = 16'h0400; c_r = 1; sram_dq_in = 16'h4242;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check($sformatf("pr_rdy_%0d", i), c_rdy, 0);
    end
    cyc();
    check("pr_rdy_5", c_rdy, 1);
    check("pr_rdata", c_rdata, 16'h4242);
    c_r = 0;
    cyc();
    check("pr_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
